// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU constants and requester identifiers for the register-file
// writeback path. Hazard and forwarding logic reuse these definitions.
package regfile_write_arbiter_pkg;

    localparam int unsigned CPU_DATA_W = 8;
    localparam int unsigned CPU_ADDR_W = 3;
    localparam int unsigned CPU_NREG   = 1 << CPU_ADDR_W;

    // Requester IDs; the value doubles as the bit index in grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // The requester that is not 'id'.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two write sources, the arbiter and the
// register-file write port. 'master' is the pipeline/register-file side,
// 'slave' is the arbiter.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned NREG   = CPU_NREG
);

    logic              A_REQ;
    logic [ADDR_W-1:0] A_ADDR;
    logic [DATA_W-1:0] A_DATA;
    logic              A_GNT;
    logic              M_REQ;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_DATA;
    logic              M_GNT;
    logic              HOLD;
    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [NREG-1:0]   PENDING;

    modport master (
        output A_REQ, A_ADDR, A_DATA, M_REQ, M_ADDR, M_DATA, HOLD,
        input  A_GNT, M_GNT, WRITE, INADDRESS, IN, PENDING
    );

    modport slave (
        input  A_REQ, A_ADDR, A_DATA, M_REQ, M_ADDR, M_DATA, HOLD,
        output A_GNT, M_GNT, WRITE, INADDRESS, IN, PENDING
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Grant bit 0 = ALU, bit 1 = MEM.
// The pointer names the requester that wins the next contested cycle and
// moves to the loser only when a contest actually happens.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_block,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_id_e r_ptr;
    req_id_e w_ptr_nxt;
    logic    w_contest;

    assign w_contest = (&i_req) && !i_block;

    // Pointer register; loads are older in the pipeline so MEM starts first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= REQ_MEM;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Next pointer: a contested cycle hands priority to the loser.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_contest) begin
            w_ptr_nxt = other_req(r_ptr);
        end
    end

    // Grant decode: nothing while blocked or in reset, else lone requester or pointer.
    always_comb begin
        o_gnt = '0;
        if (!i_rst && !i_block) begin
            if (&i_req) begin
                o_gnt = (r_ptr == REQ_ALU) ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU result path and the
// load path: round-robin grant, one registered write stage, and a
// pending-write scoreboard for the hazard unit.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned NREG   = CPU_NREG
)(
    input  logic                    CLK,
    input  logic                    RESET,
    regfile_write_arbiter_if.slave  bus
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_inaddress;
    logic [DATA_W-1:0] r_in;
    logic [NREG-1:0]   w_pending;

    assign w_req = {bus.M_REQ, bus.A_REQ};

    rr_arbiter2 u_arb (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_block (bus.HOLD),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign bus.A_GNT = w_gnt[0];
    assign bus.M_GNT = w_gnt[1];

    // Write stage: capture the granted request; address/data hold when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_write     <= 1'b0;
            r_inaddress <= '0;
            r_in        <= '0;
        end else if (w_gnt[0]) begin
            r_write     <= 1'b1;
            r_inaddress <= bus.A_ADDR;
            r_in        <= bus.A_DATA;
        end else if (w_gnt[1]) begin
            r_write     <= 1'b1;
            r_inaddress <= bus.M_ADDR;
            r_in        <= bus.M_DATA;
        end else begin
            r_write     <= 1'b0;
        end
    end

    // Scoreboard: a register is pending while a write to it waits or sits in the stage.
    always_comb begin
        w_pending = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            w_pending[r] = (bus.A_REQ && !w_gnt[0] && (bus.A_ADDR == ADDR_W'(r))) ||
                           (bus.M_REQ && !w_gnt[1] && (bus.M_ADDR == ADDR_W'(r))) ||
                           (r_write && (r_inaddress == ADDR_W'(r)));
        end
    end

    assign bus.WRITE     = r_write;
    assign bus.INADDRESS = r_inaddress;
    assign bus.IN        = r_in;
    assign bus.PENDING   = w_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a directed vector table,
// a hand-written HOLD sequence, then randomized traffic against a
// behavioural model of the grant rules, write stage and register file.
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3), .NREG(8)) bus ();

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .NREG(8)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       hold;
        logic       areq;
        logic [2:0] aaddr;
        logic [7:0] adata;
        logic       mreq;
        logic [2:0] maddr;
        logic [7:0] mdata;
        logic       eag;
        logic       emg;
        logic [7:0] epend;
        logic       ewr;
        logic [2:0] eaddr;
        logic [7:0] edata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic       m_rr_mem;   // 1: MEM wins the next contest
    logic       m_wr;
    logic [2:0] m_waddr;
    logic [7:0] m_wdata;
    logic [7:0] m_rf  [8];
    logic [7:0] tb_rf [8];  // register file fed by the DUT outputs
    logic       exp_ag, exp_mg;

    always @(posedge clk) begin
        if (bus.WRITE === 1'b1) tb_rf[bus.INADDRESS] <= bus.IN;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic h,
                                input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                                input logic mr, input logic [2:0] ma, input logic [7:0] md,
                                input logic eag, input logic emg, input logic [7:0] ep,
                                input logic ew, input logic [2:0] ea, input logic [7:0] ed);
        vec_t v;
        v.rst = r; v.hold = h;
        v.areq = ar; v.aaddr = aa; v.adata = ad;
        v.mreq = mr; v.maddr = ma; v.mdata = md;
        v.eag = eag; v.emg = emg; v.epend = ep;
        v.ewr = ew; v.eaddr = ea; v.edata = ed;
        return v;
    endfunction

    // Drive one cycle, check combinational outputs before the edge and
    // registered outputs after it, advancing the model at the edge.
    task automatic apply(input vec_t v, input bit use_exp);
        logic       ag, mg;
        logic [7:0] ep;
        @(negedge clk);
        rst        = v.rst;
        bus.HOLD   = v.hold;
        bus.A_REQ  = v.areq;
        bus.A_ADDR = v.aaddr;
        bus.A_DATA = v.adata;
        bus.M_REQ  = v.mreq;
        bus.M_ADDR = v.maddr;
        bus.M_DATA = v.mdata;
        #1;
        ag = 1'b0;
        mg = 1'b0;
        if (!v.rst && !v.hold) begin
            if (v.areq && v.mreq) begin
                if (m_rr_mem) mg = 1'b1;
                else          ag = 1'b1;
            end else begin
                ag = v.areq;
                mg = v.mreq;
            end
        end
        ep = '0;
        for (int i = 0; i < 8; i++) begin
            if ((v.areq && !ag && v.aaddr == 3'(i)) ||
                (v.mreq && !mg && v.maddr == 3'(i)) ||
                (m_wr && m_waddr == 3'(i)))
                ep[i] = 1'b1;
        end
        exp_ag = ag;
        exp_mg = mg;
        check("A_GNT", 32'(bus.A_GNT), 32'(ag));
        check("M_GNT", 32'(bus.M_GNT), 32'(mg));
        check("PENDING", 32'(bus.PENDING), 32'(ep));
        if (use_exp) begin
            check("tbl A_GNT", 32'(bus.A_GNT), 32'(v.eag));
            check("tbl M_GNT", 32'(bus.M_GNT), 32'(v.emg));
            check("tbl PENDING", 32'(bus.PENDING), 32'(v.epend));
        end
        @(posedge clk);
        if (m_wr) m_rf[m_waddr] = m_wdata;
        if (v.rst) begin
            m_wr = 1'b0; m_waddr = '0; m_wdata = '0; m_rr_mem = 1'b1;
        end else begin
            if (ag) begin
                m_wr = 1'b1; m_waddr = v.aaddr; m_wdata = v.adata;
            end else if (mg) begin
                m_wr = 1'b1; m_waddr = v.maddr; m_wdata = v.mdata;
            end else begin
                m_wr = 1'b0;
            end
            if (!v.hold && v.areq && v.mreq) m_rr_mem = ag;
        end
        #1;
        check("WRITE", 32'(bus.WRITE), 32'(m_wr));
        check("INADDRESS", 32'(bus.INADDRESS), 32'(m_waddr));
        check("IN", 32'(bus.IN), 32'(m_wdata));
        if (use_exp) begin
            check("tbl WRITE", 32'(bus.WRITE), 32'(v.ewr));
            check("tbl INADDRESS", 32'(bus.INADDRESS), 32'(v.eaddr));
            check("tbl IN", 32'(bus.IN), 32'(v.edata));
        end
    endtask

    vec_t tbl [$];
    vec_t idle;

    initial begin
        logic       ar, mr;
        logic [2:0] aa, ma;
        logic [7:0] ad, md;
        logic       rr, hh;

        rst = 1'b1;
        bus.HOLD = 1'b0;
        bus.A_REQ = 1'b0; bus.A_ADDR = '0; bus.A_DATA = '0;
        bus.M_REQ = 1'b0; bus.M_ADDR = '0; bus.M_DATA = '0;
        m_rr_mem = 1'b1; m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
        exp_ag = 1'b0; exp_mg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_rf[i] = '0;
            tb_rf[i] = '0;
        end
        @(posedge clk);
        @(posedge clk);

        //          rst hold aR aA aD   mR mA mD   eAG eMG ePEND  eWR eADDR eDATA
        tbl.push_back(mk(1, 0, 1, 3, 42,  0, 0, 0,   0, 0, 8'h08, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 42,  0, 0, 0,   0, 0, 8'h08, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 42,  0, 0, 0,   1, 0, 8'h00, 1, 3, 42));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 8'h08, 0, 3, 42));
        tbl.push_back(mk(0, 0, 1, 4, 7,   1, 4, 11,  0, 1, 8'h10, 1, 4, 11));
        tbl.push_back(mk(0, 0, 1, 4, 7,   0, 0, 0,   1, 0, 8'h10, 1, 4, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 8'h10, 0, 4, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 8'h00, 0, 4, 7));
        tbl.push_back(mk(1, 0, 1, 1, 5,   1, 2, 9,   0, 0, 8'h06, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 5,   1, 2, 9,   0, 1, 8'h02, 1, 2, 9));
        tbl.push_back(mk(0, 0, 1, 1, 5,   0, 0, 0,   1, 0, 8'h04, 1, 1, 5));
        tbl.push_back(mk(0, 1, 1, 5, 85,  1, 6, 102, 0, 0, 8'h62, 0, 1, 5));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 1, 0, 8'h40, 1, 5, 85));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 0, 1, 8'h20, 1, 6, 102));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 1, 0, 8'h40, 1, 5, 85));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 0, 1, 8'h20, 1, 6, 102));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 1, 0, 8'h40, 1, 5, 85));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 0, 1, 8'h20, 1, 6, 102));
        tbl.push_back(mk(0, 0, 1, 5, 85,  1, 6, 102, 1, 0, 8'h40, 1, 5, 85));
        tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 8'h20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 8'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1);
        end
        check("rf[3] single write", 32'(tb_rf[3]), 32'd42);
        check("rf[4] same-addr final", 32'(tb_rf[4]), 32'd7);

        // HOLD for three cycles with a load waiting, then release.
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 1, 0, 0, 0, 1, 7, 8'hA5, 0, 0, 8'h80, 0, 0, 0), 1'b1);
        end
        apply(mk(0, 0, 0, 0, 0, 1, 7, 8'hA5, 0, 1, 8'h00, 1, 7, 8'hA5), 1'b1);
        apply(idle, 1'b0);
        apply(idle, 1'b0);
        check("rf[7] after hold", 32'(tb_rf[7]), 32'hA5);

        // Randomized traffic; a requester keeps REQ/ADDR/DATA until granted.
        ar = 1'b0; mr = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
        exp_ag = 1'b0; exp_mg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(ar && !exp_ag) || exp_ag) begin
                ar = 1'($urandom_range(0, 1));
                aa = 3'($urandom_range(0, 7));
                ad = 8'($urandom);
            end
            if (!(mr && !exp_mg) || exp_mg) begin
                mr = 1'($urandom_range(0, 1));
                ma = 3'($urandom_range(0, 7));
                md = 8'($urandom);
            end
            rr = ($urandom_range(0, 31) == 0);
            hh = ($urandom_range(0, 5) == 0);
            apply(mk(rr, hh, ar, aa, ad, mr, ma, md, 0, 0, 0, 0, 0, 0), 1'b0);
        end
        apply(idle, 1'b0);
        apply(idle, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rf[%0d] random", i), 32'(tb_rf[i]), 32'(m_rf[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
